load_extend_unit: RTL and testbench

Registered load-data formatter for the data-memory read path. It takes the aligned 32-bit memory word, the load type and the address byte offset. It selects the addressed byte, half-word or partial word, then sign- or zero-extends it to 32 bits and registers the result for the write-back stage. Extension is performed by two parameterized combinational sub-modules, `sign_extend` and `zero_extend`.

---
 rtl/load_extend_unit_pkg.sv | 21 ++
 rtl/load_extend_unit_if.sv | 23 ++
 rtl/sign_extend.sv | 20 ++
 rtl/zero_extend.sv | 19 +
 rtl/load_extend_unit.sv | 94 +++++++++
 tb/tb_load_extend_unit.sv | 119 +++++++++++
 6 files changed

// File: rtl/load_extend_unit_pkg.sv
// Shared load-type codes and datapath widths for the load formatter.
// Pure definitions: no logic, no latency, no flow control.
package load_extend_unit_pkg;

  localparam int WORD = 32;
  localparam int HALF = 16;
  localparam int BYTE = 8;

  // Bit 0 doubles as the signed/unsigned select for byte and half loads
  typedef enum logic [2:0] {
    LT_W    = 3'b000,
    LT_RSVD = 3'b001,
    LT_HU   = 3'b010,
    LT_H    = 3'b011,
    LT_BU   = 3'b100,
    LT_B    = 3'b101,
    LT_WL   = 3'b110,
    LT_WR   = 3'b111
  } load_type_e;

endpackage

// File: rtl/load_extend_unit_if.sv
// Load-request inputs and formatted-result outputs of the load formatter.
// The master drives requests; the slave returns results one cycle later, with no backpressure.
interface load_extend_unit_if;
  import load_extend_unit_pkg::*;

  logic                in_valid;
  load_type_e          ld_type;
  logic [1:0]          offset;
  logic [WORD-1:0]     word_in;
  logic                out_valid;
  logic [WORD-1:0]     out_data;

  modport master (
    output in_valid, ld_type, offset, word_in,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, ld_type, offset, word_in,
    output out_valid, out_data
  );

endinterface

// File: rtl/sign_extend.sv
// Combinational sign extension of an IN_WIDTH field to OUT_WIDTH (OUT_WIDTH >= IN_WIDTH).
// Zero latency, no flow control.
module sign_extend #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  in,
  output logic [OUT_WIDTH-1:0] out
);

  // A zero-count replication is illegal, so equal widths take a straight wire
  generate
    if (OUT_WIDTH == IN_WIDTH) begin : g_pass
      assign out = in;
    end else begin : g_ext
      assign out = {{(OUT_WIDTH-IN_WIDTH){in[IN_WIDTH-1]}}, in};
    end
  endgenerate

endmodule

// File: rtl/zero_extend.sv
// Combinational zero extension of an IN_WIDTH field to OUT_WIDTH (OUT_WIDTH >= IN_WIDTH).
// Zero latency, no flow control.
module zero_extend #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  in,
  output logic [OUT_WIDTH-1:0] out
);

  generate
    if (OUT_WIDTH == IN_WIDTH) begin : g_pass
      assign out = in;
    end else begin : g_ext
      assign out = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, in};
    end
  endgenerate

endmodule

// File: rtl/load_extend_unit.sv
// Selects the addressed byte/half/partial word of a memory word and extends it to 32 bits.
// One-cycle registered latency; accepts a load every cycle, no backpressure.
module load_extend_unit
  import load_extend_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  load_extend_unit_if.slave   bus
);

  logic [BYTE-1:0] b0, b1, b2, b3;
  logic [HALF-1:0] h0, h1;
  logic [BYTE-1:0] byte_sel;
  logic [HALF-1:0] half_sel;
  logic [WORD-1:0] byte_s, byte_u, half_s, half_u;
  logic [WORD-1:0] fmt_data;

  logic [WORD-1:0] out_data_d, out_data_q;
  logic            out_valid_d, out_valid_q;

  assign {b3, b2, b1, b0} = bus.word_in;
  assign h0 = {b1, b0};
  assign h1 = {b3, b2};

  always_comb begin
    byte_sel = b0;
    case (bus.offset)
      2'd0:    byte_sel = b0;
      2'd1:    byte_sel = b1;
      2'd2:    byte_sel = b2;
      default: byte_sel = b3;
    endcase
  end

  // Misaligned half offsets fold onto h1; alignment traps live elsewhere
  assign half_sel = (bus.offset == 2'd0) ? h0 : h1;

  sign_extend #(.IN_WIDTH(BYTE), .OUT_WIDTH(WORD)) u_byte_sext (.in(byte_sel), .out(byte_s));
  zero_extend #(.IN_WIDTH(BYTE), .OUT_WIDTH(WORD)) u_byte_zext (.in(byte_sel), .out(byte_u));
  sign_extend #(.IN_WIDTH(HALF), .OUT_WIDTH(WORD)) u_half_sext (.in(half_sel), .out(half_s));
  zero_extend #(.IN_WIDTH(HALF), .OUT_WIDTH(WORD)) u_half_zext (.in(half_sel), .out(half_u));

  always_comb begin
    fmt_data = '0;
    case (bus.ld_type)
      LT_W:  fmt_data = bus.word_in;
      LT_HU: fmt_data = half_u;
      LT_H:  fmt_data = half_s;
      LT_BU: fmt_data = byte_u;
      LT_B:  fmt_data = byte_s;
      // Partial words are zero-filled; the register merge happens in write-back
      LT_WL: begin
        case (bus.offset)
          2'd0:    fmt_data = {b0, 24'h0};
          2'd1:    fmt_data = {h0, 16'h0};
          2'd2:    fmt_data = {b2, h0, 8'h0};
          default: fmt_data = bus.word_in;
        endcase
      end
      LT_WR: begin
        case (bus.offset)
          2'd0:    fmt_data = bus.word_in;
          2'd1:    fmt_data = {8'h0, h1, b1};
          2'd2:    fmt_data = {16'h0, h1};
          default: fmt_data = {24'h0, b3};
        endcase
      end
      default: fmt_data = '0;
    endcase
  end

  // Idle cycles hold the old result so garbage on type/offset never reaches the output
  always_comb begin
    out_valid_d = bus.in_valid;
    out_data_d  = out_data_q;
    if (bus.in_valid) begin
      out_data_d = fmt_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_load_extend_unit.sv
// Directed-vector bench for load_extend_unit with hand-computed expectations.
module tb_load_extend_unit;
  import load_extend_unit_pkg::*;

  localparam logic [31:0] WORD_IN = 32'h8070F0A5;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  load_extend_unit_if bus();

  load_extend_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic run_load(input string tag, input load_type_e t, input logic [1:0] off,
                          input logic [31:0] exp);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ld_type  = t;
    bus.offset   = off;
    bus.word_in  = WORD_IN;
    @(posedge clk);
    #1;
    check(tag, bus.out_data, exp);
    check({tag, "_vld"}, {31'b0, bus.out_valid}, 32'd1);
  endtask

  logic [31:0] held;

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.ld_type  = LT_W;
    bus.offset   = 2'd0;
    bus.word_in  = '0;

    #2;
    check("rst_data", bus.out_data, 32'h0);
    check("rst_vld", {31'b0, bus.out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_load("lb_o0",  LT_B,  2'd0, 32'hFFFFFFA5);
    run_load("lbu_o0", LT_BU, 2'd0, 32'h000000A5);
    run_load("lb_o2",  LT_B,  2'd2, 32'h00000070);
    run_load("lbu_o1", LT_BU, 2'd1, 32'h000000F0);
    run_load("lh_o2",  LT_H,  2'd2, 32'hFFFF8070);
    run_load("lhu_o2", LT_HU, 2'd2, 32'h00008070);
    run_load("lh_o0",  LT_H,  2'd0, 32'hFFFFF0A5);
    run_load("lw",     LT_W,  2'd2, 32'h8070F0A5);
    run_load("lwl_o0", LT_WL, 2'd0, 32'hA5000000);
    run_load("lwl_o1", LT_WL, 2'd1, 32'hF0A50000);
    run_load("lwl_o2", LT_WL, 2'd2, 32'h70F0A500);
    run_load("lwl_o3", LT_WL, 2'd3, 32'h8070F0A5);
    run_load("lwr_o0", LT_WR, 2'd0, 32'h8070F0A5);
    run_load("lwr_o1", LT_WR, 2'd1, 32'h008070F0);
    run_load("lwr_o2", LT_WR, 2'd2, 32'h00008070);
    run_load("lwr_o3", LT_WR, 2'd3, 32'h00000080);
    run_load("rsvd",   LT_RSVD, 2'd1, 32'h00000000);

    // Idle hold: last valid result must stay while inputs change underneath
    run_load("lh_o0b", LT_H, 2'd0, 32'hFFFFF0A5);
    held = 32'hFFFFF0A5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.ld_type  = LT_B;
    bus.offset   = 2'd3;
    bus.word_in  = 32'h12345678;
    @(posedge clk);
    #1;
    check("idle_vld", {31'b0, bus.out_valid}, 32'd0);
    check("idle_hold", bus.out_data, held);
    @(posedge clk);
    #1;
    check("idle_hold2", bus.out_data, held);

    // Asynchronous reset between edges while a load is in flight
    run_load("pre_rst", LT_W, 2'd0, 32'h8070F0A5);
    #2;
    reset = 1'b0;
    #1;
    check("arst_data", bus.out_data, 32'h0);
    check("arst_vld", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_data", bus.out_data, 32'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_vld", {31'b0, bus.out_valid}, 32'd0);
    check("post_rst_data", bus.out_data, 32'h0);
    run_load("lb_o3", LT_B, 2'd3, 32'hFFFFFF80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
